// File: rtl/dynamic_stream_concat_pkg.sv
// Shared types and helpers for the N-segment stream concatenator.
package dynamic_stream_concat_pkg;

  localparam int MAX_SEG = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  // Next set bit of mask strictly above idx (idx may be -1); nseg when none.
  function automatic int unsigned next_enabled(input logic [MAX_SEG-1:0] mask,
                                               input int idx,
                                               input int unsigned nseg);
    int unsigned res;
    res = nseg;
    for (int unsigned i = MAX_SEG; i > 0; i--) begin
      if ((i - 1) < nseg && int'(i - 1) > idx && mask[i-1]) res = i - 1;
    end
    return res;
  endfunction

  // Number of meaningful bytes in a word: empty only counts on eop.
  function automatic int unsigned valid_bytes(input logic eop,
                                              input int unsigned empty,
                                              input int unsigned w);
    return eop ? (w - empty) : w;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: data byte 0 sits in the MSBs, empty counts LSB-side bytes.
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) ();
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               rdy;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/dynamic_stream_concat_packer.sv
// Combines r residue bytes with n input bytes on a 2W-byte vector.
module byte_residue_packer #(
  parameter int W = 4
) (
  input  logic [W*8-1:0]       res,
  input  logic [$clog2(W)-1:0] r,
  input  logic [W*8-1:0]       in_data,
  input  logic [$clog2(W):0]   n,
  output logic [W*8-1:0]       out_word,
  output logic [W*8-1:0]       new_res,
  output logic [$clog2(W):0]   t,
  output logic                 word_ready
);
  localparam int DW = W * 8;
  localparam int RW = $clog2(W);

  logic [DW-1:0]   keep;
  logic [2*DW-1:0] comb;

  // Residue bytes are kept zero past r, so only the input needs masking
  // before it is shifted in behind the residue.
  always_comb begin
    keep       = ~({DW{1'b1}} >> (32'(n) * 8));
    comb       = {res, {DW{1'b0}}} | ({in_data & keep, {DW{1'b0}}} >> (32'(r) * 8));
    t          = {1'b0, r} + n;
    word_ready = (t >= (RW+1)'(W));
    out_word   = comb[2*DW-1 -: DW];
    new_res    = word_ready ? comb[DW-1:0] : comb[2*DW-1 -: DW];
  end
endmodule

// File: rtl/dynamic_stream_concat.sv
// Byte-packs enabled input segments, in index order, into one output packet.
module dynamic_stream_concat
  import dynamic_stream_concat_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int NUM_SEGMENTS        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SEGMENTS-1:0] seg_en,
  avalon_st_if.slave              seg_in_st [NUM_SEGMENTS],
  avalon_st_if.master             msg_out_st,
  output logic                    busy,
  output logic                    pkt_done
);
  localparam int W  = DATA_WIDTH_IN_BYTES;
  localparam int DW = W * 8;
  localparam int RW = $clog2(W);
  localparam int CW = $clog2(NUM_SEGMENTS);
  localparam logic [RW:0] W_T = (RW+1)'(W);

  state_t                  state;
  logic [NUM_SEGMENTS-1:0] en_q;
  logic [CW-1:0]           cur;
  logic                    first_out;
  logic [DW-1:0]           res_q;
  logic [RW-1:0]           r_q;
  logic                    out_valid, out_sop, out_eop;
  logic [DW-1:0]           out_data;
  logic [RW-1:0]           out_empty;

  logic [NUM_SEGMENTS-1:0] sv, se;
  logic [DW-1:0]           sd  [NUM_SEGMENTS];
  logic [RW-1:0]           sem [NUM_SEGMENTS];

  logic                    out_free, accept, last;
  logic [MAX_SEG-1:0]      en_pad, seg_pad;
  int unsigned             nxt_idx, first_idx;
  logic [RW:0]             n, t;
  logic [DW-1:0]           out_word, new_res;
  logic                    word_ready;

  assign out_free = ~out_valid | msg_out_st.rdy;

  // Flatten the interface array so the current segment can be selected by cur.
  for (genvar gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_seg
    assign sv[gi]  = seg_in_st[gi].valid;
    assign se[gi]  = seg_in_st[gi].eop;
    assign sd[gi]  = seg_in_st[gi].data;
    assign sem[gi] = seg_in_st[gi].empty;
    assign seg_in_st[gi].rdy = (state == ACTIVE) && (cur == CW'(gi)) && out_free;
  end

  // Segment selection and byte count of the word on the current segment.
  always_comb begin
    en_pad  = '0;
    seg_pad = '0;
    en_pad[NUM_SEGMENTS-1:0]  = en_q;
    seg_pad[NUM_SEGMENTS-1:0] = seg_en;
    nxt_idx   = next_enabled(en_pad, int'({1'b0, cur}), NUM_SEGMENTS);
    first_idx = next_enabled(seg_pad, -1, NUM_SEGMENTS);
    last      = (nxt_idx >= NUM_SEGMENTS);
    accept    = (state == ACTIVE) && sv[cur] && out_free;
    n         = (RW+1)'(valid_bytes(se[cur], 32'(sem[cur]), W));
  end

  byte_residue_packer #(.W(W)) u_packer (
    .res        (res_q),
    .r          (r_q),
    .in_data    (sd[cur]),
    .n          (n),
    .out_word   (out_word),
    .new_res    (new_res),
    .t          (t),
    .word_ready (word_ready)
  );

  assign msg_out_st.valid = out_valid;
  assign msg_out_st.data  = out_data;
  assign msg_out_st.sop   = out_sop;
  assign msg_out_st.eop   = out_eop;
  assign msg_out_st.empty = out_empty;
  assign busy             = (state != IDLE);

  // FSM, residue register and output register; a drain and a load may
  // coincide, the load being written last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      en_q      <= '0;
      cur       <= '0;
      first_out <= 1'b0;
      res_q     <= '0;
      r_q       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (out_valid && msg_out_st.rdy) begin
        out_valid <= 1'b0;
        if (out_eop) pkt_done <= 1'b1;
      end
      case (state)
        IDLE: begin
          en_q <= seg_en;
          if (|seg_en) begin
            cur       <= CW'(first_idx);
            first_out <= 1'b1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (se[cur] && last) begin
              out_valid <= 1'b1;
              out_data  <= out_word;
              out_sop   <= first_out;
              first_out <= 1'b0;
              if (t <= W_T) begin
                out_eop   <= 1'b1;
                out_empty <= RW'(W_T - t);
                r_q       <= '0;
                res_q     <= '0;
                state     <= IDLE;
              end else begin
                out_eop   <= 1'b0;
                out_empty <= '0;
                r_q       <= RW'(t - W_T);
                res_q     <= new_res;
                state     <= FLUSH;
              end
            end else begin
              if (word_ready) begin
                out_valid <= 1'b1;
                out_data  <= out_word;
                out_sop   <= first_out;
                out_eop   <= 1'b0;
                out_empty <= '0;
                first_out <= 1'b0;
              end
              r_q   <= RW'(t);
              res_q <= new_res;
              if (se[cur]) cur <= CW'(nxt_idx);
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_data  <= res_q;
            out_sop   <= first_out;
            out_eop   <= 1'b1;
            out_empty <= RW'(W_T - {1'b0, r_q});
            first_out <= 1'b0;
            r_q       <= '0;
            res_q     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dynamic_stream_concat.sv
// Directed table-driven bench for dynamic_stream_concat (W=4, N=3).
module tb_dynamic_stream_concat;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] seg_en = '0;
  logic       busy, pkt_done;

  avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) seg [3] ();
  avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) outs ();

  dynamic_stream_concat #(.DATA_WIDTH_IN_BYTES(4), .NUM_SEGMENTS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_en     (seg_en),
    .seg_in_st  (seg),
    .msg_out_st (outs),
    .busy       (busy),
    .pkt_done   (pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    int          cyc;
  } oword_t;

  typedef struct {
    logic [2:0] en;
    int         l0, l1, l2;
    bit         rr;
    bit         hold1;
    int         ew;
    int         ee;
    bit         tput;
  } vec_t;

  int          cks = 0;
  int          errs = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  byte unsigned segq [3][$];
  int          curn [3];
  bit          hold [3];
  bit          rdy_seen [3];
  bit          rr_mode = 0;
  bit          rdy_fix = 1;
  oword_t      wq [$];

  task automatic chk(input string nm, input longint got, input longint exp);
    cks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output ready: fixed level or a coin flip each cycle.
  initial begin
    outs.rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      outs.rdy = rr_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // One source per segment: present up to 4 queued bytes, pop on handshake.
  for (genvar g = 0; g < 3; g++) begin : g_drv
    initial begin
      bit          hs;
      int          n;
      logic [31:0] d;
      seg[g].valid = 1'b0;
      seg[g].data  = '0;
      seg[g].sop   = 1'b0;
      seg[g].eop   = 1'b0;
      seg[g].empty = '0;
      curn[g] = 0;
      forever begin
        @(negedge clk);
        hs = seg[g].valid && seg[g].rdy && rst;
        @(posedge clk);
        #1;
        if (hs) repeat (curn[g]) if (segq[g].size() > 0) void'(segq[g].pop_front());
        if (segq[g].size() > 0) begin
          n = (segq[g].size() > 4) ? 4 : segq[g].size();
          d = 32'hEEEEEEEE;
          for (int k = 0; k < n; k++) d[31-8*k -: 8] = segq[g][k];
          seg[g].data  = d;
          seg[g].valid = 1'b1;
          seg[g].eop   = (segq[g].size() <= 4);
          seg[g].empty = (segq[g].size() <= 4) ? 2'(4 - n) : 2'd0;
          curn[g] = n;
        end else if (hold[g]) begin
          seg[g].data  = 32'hDEADBEEF;
          seg[g].valid = 1'b1;
          seg[g].eop   = 1'b0;
          seg[g].empty = '0;
          curn[g] = 0;
        end else begin
          seg[g].valid = 1'b0;
          seg[g].eop   = 1'b0;
          curn[g] = 0;
        end
      end
    end
    always @(negedge clk) if (seg[g].rdy) rdy_seen[g] = 1'b1;
  end

  // Output monitor: collect accepted words, check hold-stability on stalls.
  initial begin
    bit     prev_stall;
    oword_t pw;
    oword_t w;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (pkt_done) done_cnt++;
      if (prev_stall && rst && outs.valid) begin
        chk("hold_data", outs.data, pw.data);
        chk("hold_flags", {outs.sop, outs.eop, outs.empty}, {pw.sop, pw.eop, pw.empty});
      end
      w.data = outs.data;
      w.sop = outs.sop;
      w.eop = outs.eop;
      w.empty = outs.empty;
      w.cyc = cyc;
      if (outs.valid && outs.rdy && rst) wq.push_back(w);
      prev_stall = rst && outs.valid && !outs.rdy;
      pw = w;
    end
  end

  task automatic run_pkt(input vec_t v, input int pid);
    byte unsigned expq [$];
    byte unsigned got [$];
    int lens [3];
    int k, bad, nsop, neop, nb;
    bit any_dis_rdy;
    lens[0] = v.l0; lens[1] = v.l1; lens[2] = v.l2;
    wq.delete();
    done_cnt = 0;
    for (int s = 0; s < 3; s++) rdy_seen[s] = 1'b0;
    hold[1] = v.hold1;
    rr_mode = v.rr;
    for (int s = 0; s < 3; s++)
      if (v.en[s])
        for (int i = 0; i < lens[s]; i++) begin
          segq[s].push_back(8'(pid * 7 + s * 85 + i * 3 + 1));
          expq.push_back(8'(pid * 7 + s * 85 + i * 3 + 1));
        end
    seg_en = v.en;
    k = 0;
    while (!busy && k < 20) begin @(posedge clk); #1; k++; end
    chk("busy_start", busy, 1);
    seg_en = '0;
    k = 0;
    while (done_cnt == 0 && k < 2000) begin @(posedge clk); #1; k++; end
    chk("pkt_done_seen", done_cnt > 0, 1);
    repeat (4) @(posedge clk);
    #1;
    nsop = 0; neop = 0;
    foreach (wq[i]) begin
      nb = wq[i].eop ? 4 - int'(wq[i].empty) : 4;
      for (int b = 0; b < nb; b++) got.push_back(wq[i].data[31-8*b -: 8]);
      nsop += int'(wq[i].sop);
      neop += int'(wq[i].eop);
    end
    chk("words", wq.size(), v.ew);
    chk("nbytes", got.size(), expq.size());
    bad = -1;
    foreach (expq[i]) if (bad < 0 && (i >= got.size() || got[i] != expq[i])) bad = i;
    chk("bytes_first_bad", bad, -1);
    if (wq.size() > 0) begin
      chk("sop_first", wq[0].sop, 1);
      chk("eop_last", wq[wq.size()-1].eop, 1);
      chk("empty_last", wq[wq.size()-1].empty, v.ee);
      if (v.tput) chk("tput", wq[wq.size()-1].cyc - wq[0].cyc, v.ew - 1);
    end
    chk("sop_count", nsop, 1);
    chk("eop_count", neop, 1);
    chk("pkt_done_count", done_cnt, 1);
    chk("busy_end", busy, 0);
    any_dis_rdy = 0;
    for (int s = 0; s < 3; s++) if (!v.en[s] && rdy_seen[s]) any_dis_rdy = 1;
    chk("disabled_rdy", any_dis_rdy, 0);
    hold[1] = 0;
    rr_mode = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [10];
  vec_t rv;

  initial begin
    int k;
    bit anyb;
    tbl[0] = '{3'b111, 6, 3, 8, 0, 0, 5, 3, 0};
    tbl[1] = '{3'b101, 5, 0, 7, 0, 1, 3, 0, 0};
    tbl[2] = '{3'b101, 3, 0, 2, 0, 0, 2, 3, 0};
    tbl[3] = '{3'b111, 8, 4, 4, 0, 0, 4, 0, 1};
    tbl[4] = '{3'b001, 4, 0, 0, 0, 0, 1, 0, 1};
    tbl[5] = '{3'b111, 3, 1, 4, 0, 0, 2, 0, 0};
    tbl[6] = '{3'b110, 0, 5, 2, 0, 0, 2, 1, 0};
    tbl[7] = '{3'b111, 1, 1, 1, 1, 0, 1, 1, 0};
    tbl[8] = '{3'b011, 7, 6, 0, 1, 0, 4, 3, 0};
    tbl[9] = '{3'b100, 0, 0, 9, 1, 0, 3, 3, 0};
    for (int s = 0; s < 3; s++) hold[s] = 0;

    #1;
    chk("rst_valid", outs.valid, 0);
    chk("rst_flags", {outs.sop, outs.eop, outs.empty}, 0);
    chk("rst_data", outs.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_seg_rdy", {seg[0].rdy, seg[1].rdy, seg[2].rdy}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_pkt(tbl[i], i);

    // Idle with nothing enabled, then a single 1-byte segment 1.
    wq.delete();
    anyb = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (busy) anyb = 1;
    end
    chk("idle_busy", anyb, 0);
    chk("idle_words", wq.size(), 0);
    rv = '{3'b010, 0, 1, 0, 0, 0, 1, 3, 0};
    run_pkt(rv, 20);
    chk("single_sop_eop", {wq[0].sop, wq[0].eop}, 2'b11);

    // Reset in the middle of a packet while the output word is held.
    rdy_fix = 0;
    wq.delete();
    for (int i = 0; i < 10; i++) segq[0].push_back(8'(8'hA0 + i));
    seg_en = 3'b001;
    k = 0;
    while (!busy && k < 20) begin @(posedge clk); #1; k++; end
    seg_en = '0;
    k = 0;
    while (!outs.valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("mid_valid_before", outs.valid, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_valid_after", outs.valid, 0);
    chk("mid_busy_after", busy, 0);
    for (int s = 0; s < 3; s++) segq[s].delete();
    rdy_fix = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_words", wq.size(), 0);
    rv = '{3'b011, 2, 3, 0, 0, 0, 2, 3, 0};
    run_pkt(rv, 21);

    // Randomised packets under random output back-pressure.
    for (int p = 0; p < 200; p++) begin
      int tot;
      rv.en = 3'($urandom_range(1, 7));
      rv.l0 = $urandom_range(1, 10);
      rv.l1 = $urandom_range(1, 10);
      rv.l2 = $urandom_range(1, 10);
      rv.rr = 1;
      rv.hold1 = !rv.en[1] && ($urandom_range(0, 1) == 1);
      tot = (rv.en[0] ? rv.l0 : 0) + (rv.en[1] ? rv.l1 : 0) + (rv.en[2] ? rv.l2 : 0);
      rv.ew = (tot + 3) / 4;
      rv.ee = rv.ew * 4 - tot;
      rv.tput = 0;
      run_pkt(rv, 30 + p);
    end

    $display("CHECKS %0d ERRORS %0d", cks, errs);
    $finish;
  end
endmodule
